star_motor_driver: RTL and testbench

- Downstream stage of the star hiding state machine.
- Consumes its 4-bit motor command word and drives two DC motor bridges, one for the grill and one for the star, using PWM and direction outputs.
- Each axis provides soft-start ramping, dead time on stop or reversal, and a per-axis travel timeout fault that protects the mechanics when a limit position is never reached.

---
 rtl/star_motor_driver.sv | 196 +++++++++++++++++++
 tb/tb_star_motor_driver.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/star_motor_driver.sv
// Dual-axis DC bridge driver (grill + star): soft-start ramp, dead time, travel timeout.
// Optional macro STAR_INTERLOCK_EN: the star axis may only move while the grill reports fully open.

module star_motor_axis #(
    parameter int          PWM_BITS       = 8,
    parameter int          DUTY_START     = 64,
    parameter int          RAMP_DIV       = 256,
    parameter int          DEAD_CYCLES    = 1000,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [1:0]          cmd,        // {fwd, rev}
    input  logic                permit,
    input  logic                fault_clr,
    input  logic [PWM_BITS-1:0] cnt,
    output logic                pwm,
    output logic                dir,
    output logic                fault,
    output logic                active
);

    typedef enum logic [2:0] {IDLE, RAMP, RUN, DEAD, FAULT} axis_state_e;

    localparam int RAMP_W = $clog2(RAMP_DIV + 1);
    localparam int DEAD_W = $clog2(DEAD_CYCLES + 1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;
    localparam logic [PWM_BITS-1:0] DUTY_PRE  = DUTY_MAX - PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0] DUTY_INIT = PWM_BITS'(DUTY_START);
    localparam logic [RAMP_W-1:0]   RAMP_LAST = RAMP_W'(RAMP_DIV - 1);
    localparam logic [DEAD_W-1:0]   DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);
    localparam logic [23:0]         TO_LAST   = TIMEOUT_CYCLES - 24'd1;

    axis_state_e         state, state_n;
    logic [PWM_BITS-1:0] duty, duty_n;
    logic                dir_r, dir_n;
    logic [RAMP_W-1:0]   ramp_cnt, ramp_n;
    logic [DEAD_W-1:0]   dead_cnt, dead_n;
    logic [23:0]         to_cnt, to_n;
    logic                keep_going;

    // A move continues only while the command still asks for the latched direction.
    assign keep_going = permit && (cmd == {dir_r, ~dir_r});
    assign active     = (state != IDLE);

    always_comb begin
        // NOTE: every next-state signal is defaulted first so no latches are inferred.
        state_n = state;
        duty_n  = duty;
        dir_n   = dir_r;
        ramp_n  = ramp_cnt;
        dead_n  = dead_cnt;
        to_n    = to_cnt;
        case (state)
            IDLE: begin
                duty_n = '0;
                if (permit && (cmd == 2'b10 || cmd == 2'b01)) begin
                    state_n = RAMP;
                    dir_n   = cmd[1];
                    duty_n  = DUTY_INIT;
                    ramp_n  = '0;
                    to_n    = '0;
                end
            end
            RAMP, RUN: begin
                if (to_cnt != '1)
                    to_n = to_cnt + 24'd1;
                if (!keep_going) begin
                    state_n = DEAD;
                    dead_n  = '0;
                    duty_n  = '0;
                end else if (to_cnt == TO_LAST) begin
                    state_n = FAULT;
                    duty_n  = '0;
                end else if (state == RAMP) begin
                    if (duty == DUTY_MAX) begin
                        state_n = RUN;
                    end else if (ramp_cnt == RAMP_LAST) begin
                        ramp_n = '0;
                        duty_n = duty + PWM_BITS'(1);
                        if (duty == DUTY_PRE)
                            state_n = RUN;
                    end else begin
                        ramp_n = ramp_cnt + RAMP_W'(1);
                    end
                end
            end
            DEAD: begin
                if (dead_cnt == DEAD_LAST)
                    state_n = IDLE;
                else
                    dead_n = dead_cnt + DEAD_W'(1);
            end
            FAULT: begin
                if (fault_clr && cmd == 2'b00) begin
                    state_n = DEAD;
                    dead_n  = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            duty     <= '0;
            dir_r    <= 1'b0;
            ramp_cnt <= '0;
            dead_cnt <= '0;
            to_cnt   <= '0;
            pwm      <= 1'b0;
            dir      <= 1'b0;
            fault    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state    <= state_n;
            duty     <= duty_n;
            dir_r    <= dir_n;
            ramp_cnt <= ramp_n;
            dead_cnt <= dead_n;
            to_cnt   <= to_n;
            pwm      <= (state == RAMP || state == RUN) &&
                        ((cnt < duty) || (duty == DUTY_MAX));
            dir      <= dir_r;
            fault    <= (state == FAULT);
        end
    end

endmodule

module star_motor_driver #(
    parameter int          PWM_BITS       = 8,
    parameter int          DUTY_START     = 64,
    parameter int          RAMP_DIV       = 256,
    parameter int          DEAD_CYCLES    = 1000,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_cmd,
    input  logic [1:0] i_grill_pos,
    input  logic       i_fault_clr,
    output logic       o_grill_pwm,
    output logic       o_grill_dir,
    output logic       o_star_pwm,
    output logic       o_star_dir,
    output logic [1:0] o_fault,
    output logic       o_busy
);

    logic [3:0]          r_cmd;
    logic [PWM_BITS-1:0] cnt;
    logic                star_permit;
    logic                grill_active;
    logic                star_active;

`ifdef STAR_INTERLOCK_EN
    assign star_permit = (i_grill_pos == 2'b01);
`else
    logic unused_grill_pos;
    assign unused_grill_pos = ^i_grill_pos;
    assign star_permit      = 1'b1;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cmd  <= '0;
            cnt    <= '0;
            o_busy <= 1'b0;
        end else begin
            r_cmd  <= i_cmd;
            cnt    <= cnt + PWM_BITS'(1);
            o_busy <= grill_active | star_active;
        end
    end

    star_motor_axis #(
        .PWM_BITS(PWM_BITS), .DUTY_START(DUTY_START), .RAMP_DIV(RAMP_DIV),
        .DEAD_CYCLES(DEAD_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_grill (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .cmd(r_cmd[3:2]), .permit(1'b1),
        .fault_clr(i_fault_clr), .cnt(cnt), .pwm(o_grill_pwm), .dir(o_grill_dir),
        .fault(o_fault[1]), .active(grill_active)
    );

    star_motor_axis #(
        .PWM_BITS(PWM_BITS), .DUTY_START(DUTY_START), .RAMP_DIV(RAMP_DIV),
        .DEAD_CYCLES(DEAD_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_star (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .cmd(r_cmd[1:0]), .permit(star_permit),
        .fault_clr(i_fault_clr), .cnt(cnt), .pwm(o_star_pwm), .dir(o_star_dir),
        .fault(o_fault[0]), .active(star_active)
    );

endmodule

// File: tb/tb_star_motor_driver.sv
// Directed self-checking bench for star_motor_driver with small parameters
// (PWM_BITS=4, DUTY_START=4, RAMP_DIV=2, DEAD_CYCLES=4, TIMEOUT_CYCLES=100).

module tb_star_motor_driver;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic [3:0] i_cmd;
    logic [1:0] i_grill_pos;
    logic       i_fault_clr;
    logic       o_grill_pwm, o_grill_dir, o_star_pwm, o_star_dir, o_busy;
    logic [1:0] o_fault;

    int checks = 0;
    int errors = 0;

    star_motor_driver #(
        .PWM_BITS(4), .DUTY_START(4), .RAMP_DIV(2), .DEAD_CYCLES(4), .TIMEOUT_CYCLES(24'd100)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_cmd(i_cmd), .i_grill_pos(i_grill_pos),
        .i_fault_clr(i_fault_clr), .o_grill_pwm(o_grill_pwm), .o_grill_dir(o_grill_dir),
        .o_star_pwm(o_star_pwm), .o_star_dir(o_star_dir), .o_fault(o_fault), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    // Held command 1000 through reset; ramp from duty 4 to 15 against the shared counter.
    task automatic test_reset();
        logic [22:0] exp_ramp;
        exp_ramp    = 23'b111111111_00000000000_111;  // bit k-3 = grill pwm after edge k
        i_rst_n     = 1'b0;
        i_cmd       = 4'b1000;
        i_grill_pos = 2'b00;
        i_fault_clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            checks++;
            if ({o_grill_pwm, o_grill_dir, o_star_pwm, o_star_dir, o_fault, o_busy} !== 7'b0) begin
                errors++;
                $display("FAIL reset_outputs: got %b expected 0000000",
                         {o_grill_pwm, o_grill_dir, o_star_pwm, o_star_dir, o_fault, o_busy});
            end
        end
        i_rst_n = 1'b1;
        step(2);
        checks++;
        if (o_grill_pwm !== 1'b0) begin
            errors++; $display("FAIL pwm_before_ramp: got %b expected 0", o_grill_pwm);
        end
        for (int k = 3; k <= 25; k++) begin
            step(1);
            checks++;
            if (o_grill_pwm !== exp_ramp[k-3]) begin
                errors++; $display("FAIL ramp_pwm edge %0d: got %b expected %b", k, o_grill_pwm, exp_ramp[k-3]);
            end
        end
        checks++;
        if ({o_grill_dir, o_busy, o_star_pwm} !== 3'b110) begin
            errors++; $display("FAIL ramp_dir_busy: got %b expected 110", {o_grill_dir, o_busy, o_star_pwm});
        end
        for (int k = 26; k <= 41; k++) begin
            step(1);
            checks++;
            if (o_grill_pwm !== 1'b1) begin
                errors++; $display("FAIL run_pwm edge %0d: got %b expected 1", k, o_grill_pwm);
            end
        end
    endtask

    // Reversal from RUN: dead time with old direction, then new ramp from DUTY_START.
    task automatic test_reverse();
        int ones = 0;
        int zeros = 0;
        i_cmd = 4'b0100;
        step(2);
        checks++;
        if (o_grill_pwm !== 1'b1) begin
            errors++; $display("FAIL rev_pwm_before_dead: got %b expected 1", o_grill_pwm);
        end
        for (int i = 0; i < 5; i++) begin
            step(1);
            checks++;
            if (o_grill_pwm !== 1'b0) begin
                errors++; $display("FAIL rev_dead_pwm cycle %0d: got %b expected 0", i, o_grill_pwm);
            end
            checks++;
            if (o_grill_dir !== 1'b1) begin
                errors++; $display("FAIL rev_dead_dir cycle %0d: got %b expected 1", i, o_grill_dir);
            end
        end
        step(1);
        checks++;
        if (o_grill_dir !== 1'b0) begin
            errors++; $display("FAIL rev_new_dir: got %b expected 0", o_grill_dir);
        end
        for (int i = 0; i < 16; i++) begin
            if (o_grill_pwm) ones++; else zeros++;
            step(1);
        end
        checks++;
        if (ones == 0 || zeros == 0) begin
            errors++; $display("FAIL rev_ramp_restart: got ones=%0d zeros=%0d expected both nonzero", ones, zeros);
        end
        checks++;
        if (o_busy !== 1'b1) begin
            errors++; $display("FAIL rev_busy: got %b expected 1", o_busy);
        end
    endtask

    // Star field 11 is a conflict and must never move; grill field 00 stops the grill.
    task automatic test_conflict();
        i_cmd = 4'b0011;
        for (int i = 0; i < 10; i++) begin
            step(1);
            checks++;
            if ({o_star_pwm, o_fault} !== 3'b000) begin
                errors++; $display("FAIL conflict_star cycle %0d: got %b expected 000", i, {o_star_pwm, o_fault});
            end
        end
        checks++;
        if ({o_busy, o_grill_pwm, o_star_dir} !== 3'b000) begin
            errors++; $display("FAIL conflict_idle: got %b expected 000", {o_busy, o_grill_pwm, o_star_dir});
        end
    endtask

    // Star held in motion past the timeout; fault clear needs a stop command too.
    task automatic test_timeout();
        i_cmd = 4'b0010;
        step(102);
        checks++;
        if ({o_fault, o_star_pwm, o_star_dir} !== 4'b0011) begin
            errors++; $display("FAIL timeout_early: got %b expected 0011", {o_fault, o_star_pwm, o_star_dir});
        end
        step(1);
        checks++;
        if ({o_fault, o_star_pwm, o_busy} !== 4'b0101) begin
            errors++; $display("FAIL timeout_fault: got %b expected 0101", {o_fault, o_star_pwm, o_busy});
        end
        i_fault_clr = 1'b1;
        step(5);
        checks++;
        if (o_fault !== 2'b01) begin
            errors++; $display("FAIL clr_ignored_with_cmd: got %b expected 01", o_fault);
        end
        i_cmd = 4'b0000;
        step(3);
        checks++;
        if ({o_fault, o_star_pwm} !== 3'b000) begin
            errors++; $display("FAIL fault_cleared: got %b expected 000", {o_fault, o_star_pwm});
        end
        step(3);
        checks++;
        if (o_busy !== 1'b1) begin
            errors++; $display("FAIL dead_busy: got %b expected 1", o_busy);
        end
        step(1);
        checks++;
        if (o_busy !== 1'b0) begin
            errors++; $display("FAIL idle_after_dead: got %b expected 0", o_busy);
        end
        i_fault_clr = 1'b0;
    endtask

    // Both axes together, reset mid-move, then a grill fault while the star keeps running.
    task automatic test_concurrent();
        logic [22:0] exp_ramp;
        exp_ramp = 23'b111111111_00000000000_111;
        i_cmd = 4'b1010;
        step(30);
        checks++;
        if ({o_grill_pwm, o_grill_dir, o_star_pwm, o_star_dir, o_busy} !== 5'b11111) begin
            errors++; $display("FAIL both_run: got %b expected 11111",
                               {o_grill_pwm, o_grill_dir, o_star_pwm, o_star_dir, o_busy});
        end
        i_rst_n = 1'b0;
        #1;
        checks++;
        if ({o_grill_pwm, o_grill_dir, o_star_pwm, o_star_dir, o_fault, o_busy} !== 7'b0) begin
            errors++; $display("FAIL async_reset_drop: got %b expected 0000000",
                               {o_grill_pwm, o_grill_dir, o_star_pwm, o_star_dir, o_fault, o_busy});
        end
        step(2);
        i_rst_n = 1'b1;
        step(2);
        for (int k = 3; k <= 25; k++) begin
            step(1);
            checks++;
            if ({o_grill_pwm, o_star_pwm} !== {2{exp_ramp[k-3]}}) begin
                errors++; $display("FAIL dual_ramp edge %0d: got %b expected %b", k,
                                   {o_grill_pwm, o_star_pwm}, {2{exp_ramp[k-3]}});
            end
        end
        for (int k = 26; k <= 41; k++) begin
            step(1);
            checks++;
            if ({o_grill_pwm, o_star_pwm} !== 2'b11) begin
                errors++; $display("FAIL dual_run edge %0d: got %b expected 11", k, {o_grill_pwm, o_star_pwm});
            end
        end
        i_cmd = 4'b1000;
        for (int i = 0; i < 7; i++) begin
            step(1);
            checks++;
            if (o_grill_pwm !== 1'b1) begin
                errors++; $display("FAIL grill_undisturbed cycle %0d: got %b expected 1", i, o_grill_pwm);
            end
        end
        i_cmd = 4'b1010;
        step(54);
        checks++;
        if ({o_fault, o_grill_pwm} !== 3'b001) begin
            errors++; $display("FAIL grill_pre_timeout: got %b expected 001", {o_fault, o_grill_pwm});
        end
        step(1);
        checks++;
        if ({o_fault, o_grill_pwm, o_star_pwm, o_star_dir, o_busy} !== 6'b100111) begin
            errors++; $display("FAIL grill_fault_star_runs: got %b expected 100111",
                               {o_fault, o_grill_pwm, o_star_pwm, o_star_dir, o_busy});
        end
        for (int i = 0; i < 10; i++) begin
            step(1);
            checks++;
            if ({o_fault, o_star_pwm} !== 3'b101) begin
                errors++; $display("FAIL star_undisturbed cycle %0d: got %b expected 101", i, {o_fault, o_star_pwm});
            end
        end
        i_cmd       = 4'b0000;
        i_fault_clr = 1'b1;
        step(3);
        checks++;
        if ({o_fault, o_grill_pwm, o_star_pwm} !== 4'b0000) begin
            errors++; $display("FAIL dual_stop: got %b expected 0000", {o_fault, o_grill_pwm, o_star_pwm});
        end
        step(4);
        checks++;
        if (o_busy !== 1'b0) begin
            errors++; $display("FAIL dual_idle: got %b expected 0", o_busy);
        end
        i_fault_clr = 1'b0;
    endtask

`ifdef STAR_INTERLOCK_EN
    // Star held off until the grill is open; grill leaving open stops the star without a fault.
    task automatic test_grill_pos();
        i_cmd       = 4'b0010;
        i_grill_pos = 2'b00;
        for (int i = 0; i < 20; i++) begin
            step(1);
            checks++;
            if ({o_star_pwm, o_busy, o_fault} !== 4'b0000) begin
                errors++; $display("FAIL interlock_hold cycle %0d: got %b expected 0000", i, {o_star_pwm, o_busy, o_fault});
            end
        end
        i_grill_pos = 2'b01;
        step(2);
        checks++;
        if (o_busy !== 1'b1) begin
            errors++; $display("FAIL interlock_release: got %b expected 1", o_busy);
        end
        step(28);
        checks++;
        if (o_star_pwm !== 1'b1) begin
            errors++; $display("FAIL interlock_run: got %b expected 1", o_star_pwm);
        end
        i_grill_pos = 2'b10;
        step(2);
        checks++;
        if ({o_star_pwm, o_fault} !== 3'b000) begin
            errors++; $display("FAIL interlock_drop: got %b expected 000", {o_star_pwm, o_fault});
        end
        for (int i = 0; i < 10; i++) begin
            step(1);
            checks++;
            if ({o_star_pwm, o_fault} !== 3'b000) begin
                errors++; $display("FAIL interlock_stay cycle %0d: got %b expected 000", i, {o_star_pwm, o_fault});
            end
        end
        i_cmd       = 4'b0000;
        i_grill_pos = 2'b00;
        step(8);
        checks++;
        if (o_busy !== 1'b0) begin
            errors++; $display("FAIL interlock_idle: got %b expected 0", o_busy);
        end
    endtask
`else
    // Without the interlock the star follows its command whatever the grill position.
    task automatic test_grill_pos();
        i_cmd       = 4'b0010;
        i_grill_pos = 2'b00;
        step(3);
        checks++;
        if ({o_busy, o_star_dir} !== 2'b11) begin
            errors++; $display("FAIL free_star_start: got %b expected 11", {o_busy, o_star_dir});
        end
        step(27);
        checks++;
        if (o_star_pwm !== 1'b1) begin
            errors++; $display("FAIL free_star_run: got %b expected 1", o_star_pwm);
        end
        i_grill_pos = 2'b10;
        for (int i = 0; i < 5; i++) begin
            step(1);
            checks++;
            if ({o_star_pwm, o_fault} !== 3'b100) begin
                errors++; $display("FAIL free_star_pos_ignored cycle %0d: got %b expected 100", i, {o_star_pwm, o_fault});
            end
        end
        i_cmd       = 4'b0000;
        i_grill_pos = 2'b00;
        step(8);
        checks++;
        if (o_busy !== 1'b0) begin
            errors++; $display("FAIL free_star_idle: got %b expected 0", o_busy);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_reverse();
        test_conflict();
        test_timeout();
        test_concurrent();
        test_grill_pos();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
